apb_fsm_controller: RTL and testbench

- APB-side sequencing FSM of the AHB-to-APB bridge.
- Consumes the pipelined address/data/select outputs of AHB_slave and drives the APB master signals (Pselx, Penable, Pwrite, Paddr, Pwdata).
- Stalls the AHB master via Hreadyout while an APB setup/access pair completes.
- Supports single reads, single writes and back-to-back pipelined writes.

---
 rtl/apb_bridge_pkg.sv | 30 +++
 rtl/apb_fsm_controller.sv | 135 +++++++++++++
 tb/tb_apb_fsm_controller.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module   : apb_bridge_pkg
// Brief    : Shared state encodings, HTRANS codes and widths for the bridge.
// Revision : 1.0
// ============================================================================
package apb_bridge_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int NSEL_DEF   = 3;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_WWAIT    = 3'd1;
    localparam logic [2:0] ST_READ     = 3'd2;
    localparam logic [2:0] ST_WRITE    = 3'd3;
    localparam logic [2:0] ST_WRITEP   = 3'd4;
    localparam logic [2:0] ST_RENABLE  = 3'd5;
    localparam logic [2:0] ST_WENABLE  = 3'd6;
    localparam logic [2:0] ST_WENABLEP = 3'd7;

    typedef logic [2:0] apb_state_t;

endpackage
`default_nettype wire

// File: rtl/apb_fsm_controller.sv
`default_nettype none
// ============================================================================
// Module   : apb_fsm_controller
// Brief    : APB-side setup/enable sequencer of the AHB-to-APB bridge.
// Revision : 1.0
// ============================================================================
module apb_fsm_controller
    import apb_bridge_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int NSEL   = NSEL_DEF
) (
    input  logic              Hclk,
    input  logic              Hresetn,
    input  logic              valid,
    input  logic [ADDR_W-1:0] Haddr,
    input  logic [ADDR_W-1:0] Haddr1,
    input  logic [ADDR_W-1:0] Haddr2,
    input  logic [DATA_W-1:0] Hwdata,
    input  logic [DATA_W-1:0] Hwdata1,
    input  logic              Hwrite,
    input  logic              Hwritereg,
    input  logic [NSEL-1:0]   tempselx,
    output logic [NSEL-1:0]   Pselx,
    output logic              Penable,
    output logic              Pwrite,
    output logic [ADDR_W-1:0] Paddr,
    output logic [DATA_W-1:0] Pwdata,
    output logic              Hreadyout
);

    apb_state_t        state_q, state_d;
    logic [NSEL-1:0]   pselx_q, pselx_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              hreadyout_q, hreadyout_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (valid) state_d = Hwrite ? ST_WWAIT : ST_READ;
            end
            ST_WWAIT:    state_d = valid ? ST_WRITEP : ST_WRITE;
            ST_READ:     state_d = ST_RENABLE;
            ST_WRITE:    state_d = valid ? ST_WENABLEP : ST_WENABLE;
            ST_WRITEP:   state_d = ST_WENABLEP;
            ST_RENABLE,
            ST_WENABLE: begin
                if (!valid)      state_d = ST_IDLE;
                else if (Hwrite) state_d = ST_WWAIT;
                else             state_d = ST_READ;
            end
            ST_WENABLEP: begin
                if (!Hwritereg)  state_d = ST_READ;
                else if (valid)  state_d = ST_WRITEP;
                else             state_d = ST_WRITE;
            end
            default:     state_d = ST_IDLE;
        endcase
    end

    // Outputs are computed for the state being entered, so they appear
    // together with the new state one cycle after the decision.
    always_comb begin
        pselx_d     = pselx_q;
        penable_d   = 1'b0;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        hreadyout_d = 1'b1;
        case (state_d)
            ST_IDLE,
            ST_WWAIT: begin
                pselx_d = '0;
            end
            ST_READ: begin
                pselx_d     = tempselx;
                pwrite_d    = 1'b0;
                paddr_d     = Haddr;
                hreadyout_d = 1'b0;
            end
            ST_WRITE,
            ST_WRITEP: begin
                pselx_d  = tempselx;
                pwrite_d = 1'b1;
                // Coming out of a pipelined enable, the address/data pair
                // of this beat has slipped one more stage down the pipe.
                if (state_q == ST_WENABLEP) begin
                    paddr_d  = Haddr2;
                    pwdata_d = Hwdata1;
                end else begin
                    paddr_d  = Haddr1;
                    pwdata_d = Hwdata;
                end
                hreadyout_d = (state_d != ST_WRITEP);
            end
            default: begin
                penable_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state_q     <= ST_IDLE;
            pselx_q     <= '0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            hreadyout_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            pselx_q     <= pselx_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            hreadyout_q <= hreadyout_d;
        end
    end

    assign Pselx     = pselx_q;
    assign Penable   = penable_q;
    assign Pwrite    = pwrite_q;
    assign Paddr     = paddr_q;
    assign Pwdata    = pwdata_q;
    assign Hreadyout = hreadyout_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_fsm_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_fsm_controller
// Brief    : Directed self-checking bench for the APB sequencing FSM.
// Revision : 1.0
// ============================================================================
module tb_apb_fsm_controller;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int NSEL   = 3;

    logic              Hclk = 1'b0;
    logic              Hresetn;
    logic              valid;
    logic [ADDR_W-1:0] Haddr, Haddr1, Haddr2;
    logic [DATA_W-1:0] Hwdata, Hwdata1;
    logic              Hwrite, Hwritereg;
    logic [NSEL-1:0]   tempselx;
    logic [NSEL-1:0]   Pselx;
    logic              Penable, Pwrite, Hreadyout;
    logic [ADDR_W-1:0] Paddr;
    logic [DATA_W-1:0] Pwdata;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // {Pselx, Penable, Pwrite, Hreadyout}
    logic [5:0] ctl;
    assign ctl = {Pselx, Penable, Pwrite, Hreadyout};

    apb_fsm_controller #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NSEL(NSEL)) dut (
        .Hclk      (Hclk),
        .Hresetn   (Hresetn),
        .valid     (valid),
        .Haddr     (Haddr),
        .Haddr1    (Haddr1),
        .Haddr2    (Haddr2),
        .Hwdata    (Hwdata),
        .Hwdata1   (Hwdata1),
        .Hwrite    (Hwrite),
        .Hwritereg (Hwritereg),
        .tempselx  (tempselx),
        .Pselx     (Pselx),
        .Penable   (Penable),
        .Pwrite    (Pwrite),
        .Paddr     (Paddr),
        .Pwdata    (Pwdata),
        .Hreadyout (Hreadyout)
    );

    always #5 Hclk = ~Hclk;

    task automatic tick();
        @(posedge Hclk);
        #1;
    endtask

    task automatic test_reset();
        Hresetn = 1'b0; valid = 1'b0; Hwrite = 1'b0; Hwritereg = 1'b0;
        Haddr = '0; Haddr1 = '0; Haddr2 = '0; Hwdata = '0; Hwdata1 = '0;
        tempselx = '0;
        tick(); tick();
        Hresetn = 1'b1;
        tick();
        total_cnt++;
        if (ctl !== 6'b000_0_0_1) $display("FAIL reset_ctl got %b want %b", ctl, 6'b000001);
        else pass_cnt++;
        total_cnt++;
        if ({Paddr, Pwdata} !== 64'h0) $display("FAIL reset_data got %h want 0", {Paddr, Pwdata});
        else pass_cnt++;
    endtask

    task automatic test_single_write();
        valid = 1'b1; Hwrite = 1'b1; Haddr = 32'h8000_0000; tempselx = 3'b001;
        tick(); // WWAIT
        total_cnt++;
        if (ctl !== 6'b000_0_0_1) $display("FAIL wr_wwait got %b want %b", ctl, 6'b000001);
        else pass_cnt++;
        valid = 1'b0; Hwrite = 1'b0; Haddr1 = 32'h8000_0000; Hwdata = 32'h1234_5678;
        tick(); // WRITE
        total_cnt++;
        if (ctl !== 6'b001_0_1_1) $display("FAIL wr_setup_ctl got %b want %b", ctl, 6'b001011);
        else pass_cnt++;
        total_cnt++;
        if ({Paddr, Pwdata} !== {32'h8000_0000, 32'h1234_5678})
            $display("FAIL wr_setup_data got %h want %h", {Paddr, Pwdata}, {32'h8000_0000, 32'h1234_5678});
        else pass_cnt++;
        Haddr1 = 32'h0; Hwdata = 32'h0;
        tick(); // WENABLE
        total_cnt++;
        if (ctl !== 6'b001_1_1_1 || Paddr !== 32'h8000_0000)
            $display("FAIL wr_enable got %b/%h want %b/%h", ctl, Paddr, 6'b001111, 32'h8000_0000);
        else pass_cnt++;
        tick(); // IDLE
        total_cnt++;
        if (ctl[5:3] !== 3'b000 || ctl[2] !== 1'b0 || Hreadyout !== 1'b1 || Pwdata !== 32'h1234_5678)
            $display("FAIL wr_idle got %b/%h want 000x01/%h", ctl, Pwdata, 32'h1234_5678);
        else pass_cnt++;
    endtask

    task automatic test_single_read();
        valid = 1'b1; Hwrite = 1'b0; Haddr = 32'h8400_0000; tempselx = 3'b010;
        tick(); // READ
        total_cnt++;
        if (ctl !== 6'b010_0_0_0 || Paddr !== 32'h8400_0000)
            $display("FAIL rd_setup got %b/%h want %b/%h", ctl, Paddr, 6'b010000, 32'h8400_0000);
        else pass_cnt++;
        valid = 1'b0;
        tick(); // RENABLE
        total_cnt++;
        if (ctl !== 6'b010_1_0_1) $display("FAIL rd_enable got %b want %b", ctl, 6'b010101);
        else pass_cnt++;
        tick(); // IDLE
        total_cnt++;
        if (ctl !== 6'b000_0_0_1) $display("FAIL rd_idle got %b want %b", ctl, 6'b000001);
        else pass_cnt++;
    endtask

    task automatic test_enable_chain();
        // RENABLE with a new valid write must go straight to WWAIT, not IDLE.
        valid = 1'b1; Hwrite = 1'b0; Haddr = 32'h8400_0004; tempselx = 3'b010;
        tick(); // READ
        tick(); // RENABLE (valid still high, still a read -> READ next)
        total_cnt++;
        if (ctl !== 6'b010_1_0_1) $display("FAIL chain_renable got %b want %b", ctl, 6'b010101);
        else pass_cnt++;
        Hwrite = 1'b1; Haddr = 32'h8000_0040; tempselx = 3'b001;
        tick(); // READ again (valid & !Hwrite was sampled? no: Hwrite=1 -> WWAIT)
        total_cnt++;
        if (ctl !== 6'b000_0_0_1) $display("FAIL chain_wwait got %b want %b", ctl, 6'b000001);
        else pass_cnt++;
        valid = 1'b0; Hwrite = 1'b0; Haddr1 = 32'h8000_0040; Hwdata = 32'hCAFE_0001;
        tick(); // WRITE
        total_cnt++;
        if (ctl !== 6'b001_0_1_1 || Pwdata !== 32'hCAFE_0001)
            $display("FAIL chain_write got %b/%h want %b/%h", ctl, Pwdata, 6'b001011, 32'hCAFE_0001);
        else pass_cnt++;
        tick(); // WENABLE
        tick(); // IDLE
    endtask

    task automatic test_back_to_back();
        valid = 1'b1; Hwrite = 1'b1; Haddr = 32'h8000_0000; tempselx = 3'b001;
        tick(); // WWAIT
        Haddr = 32'h8400_0000; Haddr1 = 32'h8000_0000; Hwdata = 32'h1111_1111;
        tick(); // WRITEP
        total_cnt++;
        if (ctl !== 6'b001_0_1_0 || {Paddr, Pwdata} !== {32'h8000_0000, 32'h1111_1111})
            $display("FAIL b2b_writep got %b/%h want %b/%h", ctl, {Paddr, Pwdata}, 6'b001010,
                     {32'h8000_0000, 32'h1111_1111});
        else pass_cnt++;
        valid = 1'b0; Hwrite = 1'b0;
        tick(); // WENABLEP
        total_cnt++;
        if (ctl !== 6'b001_1_1_1) $display("FAIL b2b_wenablep got %b want %b", ctl, 6'b001111);
        else pass_cnt++;
        Hwritereg = 1'b1; Haddr2 = 32'h8400_0000; Hwdata1 = 32'h2222_2222;
        Haddr1 = 32'hDEAD_0000; Hwdata = 32'hBAD0_BAD0; tempselx = 3'b010;
        tick(); // WRITE
        total_cnt++;
        if (ctl !== 6'b010_0_1_1 || {Paddr, Pwdata} !== {32'h8400_0000, 32'h2222_2222})
            $display("FAIL b2b_write2 got %b/%h want %b/%h", ctl, {Paddr, Pwdata}, 6'b010011,
                     {32'h8400_0000, 32'h2222_2222});
        else pass_cnt++;
        Hwritereg = 1'b0;
        tick(); // WENABLE
        total_cnt++;
        if (ctl !== 6'b010_1_1_1) $display("FAIL b2b_wenable got %b want %b", ctl, 6'b010111);
        else pass_cnt++;
        tick(); // IDLE
        total_cnt++;
        if (ctl[5:4] !== 2'b00 || ctl[3] !== 1'b0 || Penable !== 1'b0)
            $display("FAIL b2b_idle got %b want 000 select, no enable", ctl);
        else pass_cnt++;
    endtask

    task automatic test_write_then_read();
        valid = 1'b1; Hwrite = 1'b1; Haddr = 32'h8000_0100; tempselx = 3'b001;
        tick(); // WWAIT
        Hwrite = 1'b0; Haddr = 32'h8800_0010; Haddr1 = 32'h8000_0100; Hwdata = 32'h5555_AAAA;
        tick(); // WRITEP
        valid = 1'b0;
        tick(); // WENABLEP
        Hwritereg = 1'b0; tempselx = 3'b100;
        tick(); // READ
        total_cnt++;
        if (ctl !== 6'b100_0_0_0 || Paddr !== 32'h8800_0010)
            $display("FAIL wtr_read got %b/%h want %b/%h", ctl, Paddr, 6'b100000, 32'h8800_0010);
        else pass_cnt++;
        tick(); // RENABLE
        total_cnt++;
        if (ctl !== 6'b100_1_0_1) $display("FAIL wtr_renable got %b want %b", ctl, 6'b100101);
        else pass_cnt++;
        tick(); // IDLE
    endtask

    task automatic test_async_reset();
        valid = 1'b1; Hwrite = 1'b1; Haddr = 32'h8000_0200; tempselx = 3'b001;
        tick(); // WWAIT
        valid = 1'b0; Hwrite = 1'b0; Haddr1 = 32'h8000_0200; Hwdata = 32'h7777_7777;
        tick(); // WRITE
        tick(); // WENABLE
        total_cnt++;
        if (ctl !== 6'b001_1_1_1) $display("FAIL ar_pre got %b want %b", ctl, 6'b001111);
        else pass_cnt++;
        #2 Hresetn = 1'b0;
        #1;
        total_cnt++;
        if (ctl !== 6'b000_0_0_1 || {Paddr, Pwdata} !== 64'h0)
            $display("FAIL ar_async got %b/%h want %b/0", ctl, {Paddr, Pwdata}, 6'b000001);
        else pass_cnt++;
        @(negedge Hclk);
        Hresetn = 1'b1;
        tick();
        total_cnt++;
        if (ctl !== 6'b000_0_0_1) $display("FAIL ar_after got %b want %b", ctl, 6'b000001);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_single_read();
        test_enable_chain();
        test_back_to_back();
        test_write_then_read();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
